// File: rtl/fifo_pkg.sv
// Shared helpers for the sync_fifo family: pointer sizing and configuration legality.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Legal configuration: power-of-two depth of at least 4, boot fill within capacity.
    function automatic bit fifo_cfg_ok(input int depth, input int boot_count);
        return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (boot_count >= 0) && (boot_count <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo: one synchronous write port, one read port.
// Latency: write 1 cycle; read 0 cycles (FWFT=1, async) or 1 cycle (FWFT=0, registered).
// Backpressure: none; the caller only enables ports on accepted transfers.
// Ports: clk/rst (rst clears the registered read output only), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr (rd_en loads the read register), rd_data.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 72,
    parameter int DEPTH      = 32,
    parameter int FWFT       = 0,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    // No reset on the array: boot contents are loaded by the instantiating module.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_async_rd
            assign rd_data = mem[rd_addr];

            // Reset and read enable have no role on an asynchronous read port.
            logic unused_rd;
            assign unused_rd = rst ^ rd_en;
        end else begin : g_reg_rd
            // Holds its value between reads; a same-cycle write to rd_addr returns old data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with FWFT/registered read, programmable thresholds, flush, sticky errors, watermark.
// Latency: status 1 cycle after a fire; FWFT=1 data visible 1 cycle after write, FWFT=0 data 1 cycle after rd_fire.
// Backpressure: writes dropped (overflow) when full unless a read fires the same cycle; reads while empty set underflow.
// Ports: clk, rst (sync, active-high), flush, wr_en/wr_data/full/almost_full/af_thresh,
//        rd_en/rd_data/rd_valid/empty/almost_empty/ae_thresh, count, peak, overflow, underflow, err_clr.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 72,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FWFT       = 0,
    parameter int BOOT_COUNT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   peak,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int PTR_W = fifo_ptr_width(DEPTH);

    if (!fifo_cfg_ok(DEPTH, BOOT_COUNT)) begin : g_bad_cfg
        $error("sync_fifo: DEPTH must be a power of 2 >= 4 and BOOT_COUNT must be 0..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [PTR_W-1:0] count_nxt;
    logic             wr_fire, rd_fire;
    logic             ovf_set, udf_set;

    // Status is derived purely from registered pointers.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == PTR_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // Flush suppresses both handshakes and any error reporting in its cycle.
    assign rd_fire = rd_en & ~flush & ~empty;
    assign wr_fire = wr_en & ~flush & (~full | rd_fire);
    assign ovf_set = wr_en & ~flush & ~wr_fire;
    assign udf_set = rd_en & ~flush & empty;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_fire) wr_ptr_nxt = wr_ptr + 1'b1;
            if (rd_fire) rd_ptr_nxt = rd_ptr + 1'b1;
        end
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= PTR_W'(BOOT_COUNT);
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            peak      <= PTR_W'(BOOT_COUNT);
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;

            // A new error in the same cycle as err_clr must not be lost.
            if (ovf_set)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;

            if (udf_set)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;

            // err_clr restarts the watermark from present occupancy, still tracking this cycle's change.
            if (err_clr)                peak <= (count_nxt > count) ? count_nxt : count;
            else if (count_nxt > peak)  peak <= count_nxt;
        end
    end

    fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .FWFT       (FWFT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft_vld
            assign rd_valid = ~empty;
        end else begin : g_reg_vld
            always_ff @(posedge clk) begin
                if (rst) rd_valid <= 1'b0;
                else     rd_valid <= rd_fire;
            end
        end
    endgenerate

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO for buffering within one clock domain, e.g. between the command decoder and the register file. Generalises the command-path FIFO with:
- selectable first-word-fall-through (FWFT) or registered-read mode;
- runtime-programmable almost-full/almost-empty thresholds;
- synchronous flush, sticky overflow/underflow error flags and a peak-occupancy watermark;
- boot pre-population (BOOT_COUNT).

## Interface
- WIDTH, 72: data width in bits.
- DEPTH, 32: entries; power of 2, ≥4.
- ADDR_WIDTH, $clog2(DEPTH): derived; do not override.
- FWFT, 0: 0 = registered read; 1 = head entry always presented on rd_data.
- BOOT_COUNT, 0: entries valid after reset; 0..DEPTH. Memory contents are initialised by the instantiating module.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all contents.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ af_thresh.
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold.
- rd_en  in  1  read request / pop.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data is valid.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ ae_thresh.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold.
- count  out  ADDR_WIDTH+1  current occupancy.
- peak  out  ADDR_WIDTH+1  maximum count since reset or err_clr.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read occurred while empty.
- err_clr  in  1  clears overflow and underflow; sets peak to the current count.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - count = wr_ptr − rd_ptr (modulo 2^(ADDR_WIDTH+1)).
  - Address = ptr[ADDR_WIDTH-1:0].
- Handshakes:
  - rd_fire = rd_en & !empty.
  - wr_fire = wr_en & (!full | rd_fire). A write to a full FIFO is accepted when a read fires in the same cycle.
  - Simultaneous wr_fire and rd_fire: count unchanged. This includes count==0 in FWFT=0 mode only if not empty; a write to an empty FIFO is never readable in the same cycle.
- Errors:
  - wr_en & !wr_fire sets overflow; data is dropped and pointers are unchanged.
  - rd_en & empty sets underflow.
  - Set wins over err_clr in the same cycle.
- Peak: updated each cycle to max(peak, next count).
- FWFT=0:
  - On rd_fire: rd_data <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
- FWFT=1:
  - rd_data = mem[rd_ptr] (asynchronous read).
  - rd_valid = !empty.
  - rd_en acts as a pop (acknowledge).
- Flush:
  - wr_ptr and rd_ptr go to 0 (not BOOT_COUNT); rd_valid goes to 0; rd_data holds.
  - flush overrides wr_en and rd_en in the same cycle: no write, no pop, no error flags set.
  - peak is unchanged.
- Reset (rst=1 at clk edge, highest priority, also mid-operation):
  - wr_ptr = BOOT_COUNT, rd_ptr = 0.
  - rd_data = 0, rd_valid = 0 (FWFT=0).
  - overflow = underflow = 0; peak = BOOT_COUNT.
  - Memory is not cleared.
- Thresholds:
  - af_thresh = 0 makes almost_full constantly 1.
  - ae_thresh ≥ DEPTH makes almost_empty constantly 1.
  - No clamping.

## Timing
- All status outputs (full, empty, almost_*, count) are combinational from registered pointers. They reflect a fire on the cycle after the edge it occurred on.
- Write-to-read latency:
  - FWFT=1: data visible and rd_valid=1 one cycle after wr_fire into an empty FIFO.
  - FWFT=0: rd_en is accepted from that cycle; data appears one cycle after rd_fire.
- Back-to-back: one write and one read per cycle sustained; throughput 1/cycle.
- Reset values: count = BOOT_COUNT; empty = (BOOT_COUNT==0); full = (BOOT_COUNT==DEPTH); almost_* follow from the thresholds.
- Wrap-around: after 2·DEPTH writes and reads, the pointers return to their initial values with no bubble.

## Structure
- fifo_pkg holds:
  - a function computing the pointer width from DEPTH;
  - an elaboration check that DEPTH is a power of 2 and BOOT_COUNT ≤ DEPTH.
- Sub-module fifo_ram:
  - WIDTH×DEPTH, one synchronous write port, one read port.
  - Read port is asynchronous (FWFT=1) or registered with enable (FWFT=0), selected by parameter.
  - The sync_fifo body holds pointers, flags, watermark and errors.

## Test plan
- DEPTH=8, WIDTH=8, FWFT=0:
  - Write 0x01..0x08 → full=1, count=8.
  - 9th write 0xFF → overflow=1, count stays 8.
  - 8 reads return 0x01..0x08, each rd_valid one cycle after rd_en.
  - empty=1 after the last read.
- Full with simultaneous wr_en(0xAA) and rd_en → read returns the head entry; count stays 8; overflow stays 0; 0xAA appears after the 7 older entries.
- FWFT=1: write 0x5C into empty → next cycle rd_data=0x5C, rd_valid=1 without rd_en; pop → empty=1.
- af_thresh=6, ae_thresh=1: fill to 5 → almost_full=0; 6th write → almost_full=1; drain to 1 → almost_empty=1; peak=6. err_clr at count=1 → peak=1.
- Errors and flush:
  - rd_en while empty → underflow=1; err_clr in the same cycle as a new underflow → underflow stays 1.
  - flush with wr_en at count=4 → count=0, no overflow.
  - rst mid-burst → all reset values as specified.
- BOOT_COUNT=3 → after reset count=3, empty=0; three reads return the preloaded words; then empty=1.
